uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/sync_byte_fifo.sv | 54 +++++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the two-port UART transmit arbiter.
// Holds the sequencer state encoding and default FIFO depth / timeout.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 200000;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO, power-of-two depth, first-word fall-through.
// Ports: push/push_data in, pop in, pop_data = head, full/empty/count.
module sync_byte_fifo
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter of two byte requesters feeding one UART sender.
// Ports: req0/req1 valid-ready, tx_* sender side, busy, count, timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [7:0]             req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [7:0]             req1_data,
  output logic                   req1_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_trigger,
  output logic                   tx_enable,
  input  logic                   tx_finish,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  state_t        state;
  state_t        state_nx;
  logic          rr;
  logic          grant0;
  logic          grant1;
  logic          push;
  logic          pop;
  logic          tmo;
  logic          full;
  logic          empty;
  logic [7:0]    push_data;
  logic [7:0]    head;
  logic [CW-1:0] cnt;

  // rr only breaks ties; a lone valid requester always wins.
  assign grant0 = req0_valid && (!req1_valid || !rr);
  assign grant1 = req1_valid && (!req0_valid || rr);

  assign req0_ready = reset && grant0 && !full;
  assign req1_ready = reset && grant1 && !full;

  assign push      = (req0_valid && req0_ready)
                  || (req1_valid && req1_ready);
  assign push_data = req0_ready ? req0_data : req1_data;

  assign tx_enable = reset;
  assign busy      = state != IDLE;

  sync_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .sysclk   (sysclk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  always_ff @(posedge sysclk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_nx = ISSUE;
      end
      ISSUE: begin
        pop      = 1'b1;
        state_nx = BUSY;
      end
      BUSY: begin
        if (tx_finish) begin
          state_nx = IDLE;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          tmo      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      tx_data     <= 8'h00;
      tx_trigger  <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      rr          <= 1'b0;
    end else begin
      if (pop) begin
        tx_data    <= head;
        tx_trigger <= ~tx_trigger;
      end
      if (pop)                cnt <= '0;
      else if (state == BUSY) cnt <= cnt + 1'b1;
      // A timeout in the same cycle as a clear keeps the flag set.
      if (tmo)          timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      // Point at whoever lost, so the next tie goes the other way.
      if (push) rr <= grant0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (DEPTH=4, TIMEOUT_CYC=16).
// One task per scenario; inline checks; one summary line at the end.
module tb_uart_tx_arbiter;

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_trigger;
  logic       tx_enable;
  logic       tx_finish = 1'b0;
  logic       busy;
  logic [2:0] fifo_count;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  int   chk = 0;
  int   pass = 0;
  logic exp_trig = 1'b0;

  uart_tx_arbiter #(
    .DEPTH(4),
    .TIMEOUT_CYC(16)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_data    (tx_data),
    .tx_trigger (tx_trigger),
    .tx_enable  (tx_enable),
    .tx_finish  (tx_finish),
    .busy       (busy),
    .fifo_count (fifo_count),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end, want end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic finish_pulse();
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tx_finish = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_trig = 1'b0;
  endtask

  // Wait (bounded) for the next trigger toggle, then check the byte.
  task automatic wait_issue(input logic [7:0] exp, input string nm);
    int n = 0;
    while (tx_trigger === exp_trig && n < 24) begin
      tick();
      n++;
    end
    chk++;
    if (tx_trigger === exp_trig) begin
      $display("FAIL %s: no trigger toggle, want byte %h", nm, exp);
    end else begin
      exp_trig = ~exp_trig;
      if (tx_data !== exp)
        $display("FAIL %s: got %h want %h", nm, tx_data, exp);
      else pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    tick();
    @(negedge sysclk);
    chk++; if (fifo_count !== 3'd0)
      $display("FAIL rst_count: got %0d want 0", fifo_count); else pass++;
    chk++; if (tx_data !== 8'h00)
      $display("FAIL rst_data: got %h want 00", tx_data); else pass++;
    chk++; if (tx_trigger !== 1'b0)
      $display("FAIL rst_trig: got %b want 0", tx_trigger); else pass++;
    chk++; if (tx_enable !== 1'b0)
      $display("FAIL rst_en: got %b want 0", tx_enable); else pass++;
    chk++; if (busy !== 1'b0)
      $display("FAIL rst_busy: got %b want 0", busy); else pass++;
    chk++; if (timeout_err !== 1'b0)
      $display("FAIL rst_err: got %b want 0", timeout_err); else pass++;
    chk++; if ({req1_ready, req0_ready} !== 2'b00)
      $display("FAIL rst_ready: got %b want 00",
               {req1_ready, req0_ready}); else pass++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk++; if (tx_enable !== 1'b1)
      $display("FAIL en_after_rst: got %b want 1", tx_enable); else pass++;
  endtask

  task automatic test_single();
    req0_valid = 1'b1;
    req0_data = 8'hA5;
    @(negedge sysclk);
    chk++; if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL single_ready: got %b want 01",
               {req1_ready, req0_ready}); else pass++;
    tick();
    req0_valid = 1'b0;
    chk++; if (fifo_count !== 3'd1 || busy !== 1'b0)
      $display("FAIL single_e0: got cnt %0d busy %b want 1 0",
               fifo_count, busy); else pass++;
    tick();
    chk++; if (busy !== 1'b1 || tx_trigger !== exp_trig)
      $display("FAIL single_e1: got busy %b trig %b want 1 %b",
               busy, tx_trigger, exp_trig); else pass++;
    tick();
    chk++; if (tx_trigger !== ~exp_trig || tx_data !== 8'hA5)
      $display("FAIL single_issue: got trig %b data %h want %b a5",
               tx_trigger, tx_data, ~exp_trig); else pass++;
    exp_trig = ~exp_trig;
    chk++; if (fifo_count !== 3'd0)
      $display("FAIL single_pop: got %0d want 0", fifo_count); else pass++;
    tick();
    tick();
    tick();
    tx_finish = 1'b1;
    @(negedge sysclk);
    chk++; if (busy !== 1'b1)
      $display("FAIL single_hold: got %b want 1", busy); else pass++;
    tick();
    tx_finish = 1'b0;
    chk++; if (busy !== 1'b0)
      $display("FAIL single_done: got %b want 0", busy); else pass++;
    tick();
  endtask

  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    int g;
    do_reset();
    req0_valid = 1'b1;
    req0_data = 8'h10;
    req1_valid = 1'b1;
    req1_data = 8'h20;
    for (int c = 0; c < 4; c++) begin
      g = c % 2;
      @(negedge sysclk);
      chk++; if (req0_ready && req1_ready)
        $display("FAIL cont_both: got 11 want one-hot at %0d", c);
      else pass++;
      chk++; if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01))
        $display("FAIL cont_grant%0d: got %b want %b", c,
                 {req1_ready, req0_ready}, (g ? 2'b10 : 2'b01));
      else pass++;
      tick();
      if (g == 0) begin
        n0++;
        req0_data = 8'h11;
        if (n0 == 2) req0_valid = 1'b0;
      end else begin
        n1++;
        req1_data = 8'h21;
        if (n1 == 2) req1_valid = 1'b0;
      end
    end
    wait_issue(8'h10, "cont_b0");
    finish_pulse();
    wait_issue(8'h20, "cont_b1");
    finish_pulse();
    wait_issue(8'h11, "cont_b2");
    finish_pulse();
    wait_issue(8'h21, "cont_b3");
    finish_pulse();
    chk++; if (fifo_count !== 3'd0 || busy !== 1'b0)
      $display("FAIL cont_drain: got cnt %0d busy %b want 0 0",
               fifo_count, busy); else pass++;
  endtask

  task automatic test_full();
    logic [2:0] exp_cnt [5];
    int peak = 0;
    exp_cnt[0] = 3'd1;
    exp_cnt[1] = 3'd2;
    exp_cnt[2] = 3'd2;
    exp_cnt[3] = 3'd3;
    exp_cnt[4] = 3'd4;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1;
      req0_data = 8'h30 + 8'(i);
      @(negedge sysclk);
      chk++; if (req0_ready !== 1'b1)
        $display("FAIL full_push%0d: got ready %b want 1", i, req0_ready);
      else pass++;
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      chk++; if (fifo_count !== exp_cnt[i])
        $display("FAIL full_cnt%0d: got %0d want %0d", i,
                 fifo_count, exp_cnt[i]); else pass++;
    end
    wait_issue(8'h30, "full_b0");
    chk++; if (peak != 4)
      $display("FAIL full_peak: got %0d want 4", peak); else pass++;
    req0_data = 8'h35;
    req1_valid = 1'b1;
    req1_data = 8'h45;
    @(negedge sysclk);
    chk++; if ({req1_ready, req0_ready} !== 2'b00)
      $display("FAIL full_blk: got %b want 00",
               {req1_ready, req0_ready}); else pass++;
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    @(negedge sysclk);
    chk++; if ({req1_ready, req0_ready} !== 2'b00 || busy !== 1'b0)
      $display("FAIL full_idle: got rdy %b busy %b want 00 0",
               {req1_ready, req0_ready}, busy); else pass++;
    tick();
    @(negedge sysclk);
    chk++; if ({req1_ready, req0_ready} !== 2'b00 || fifo_count !== 3'd4)
      $display("FAIL full_popcyc: got rdy %b cnt %0d want 00 4",
               {req1_ready, req0_ready}, fifo_count); else pass++;
    tick();
    chk++; if (tx_trigger !== ~exp_trig || tx_data !== 8'h31)
      $display("FAIL full_b1: got trig %b data %h want %b 31",
               tx_trigger, tx_data, ~exp_trig); else pass++;
    exp_trig = ~exp_trig;
    @(negedge sysclk);
    chk++; if ({req1_ready, req0_ready} !== 2'b10)
      $display("FAIL full_reopen: got %b want 10",
               {req1_ready, req0_ready}); else pass++;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk++; if (fifo_count !== 3'd4)
      $display("FAIL full_refill: got %0d want 4", fifo_count); else pass++;
    finish_pulse();
    wait_issue(8'h32, "full_b2");
    finish_pulse();
    wait_issue(8'h33, "full_b3");
    finish_pulse();
    wait_issue(8'h34, "full_b4");
    finish_pulse();
    wait_issue(8'h45, "full_b5");
    finish_pulse();
  endtask

  task automatic test_timeout();
    req0_valid = 1'b1;
    req0_data = 8'h50;
    tick();
    req0_data = 8'h51;
    tick();
    req0_valid = 1'b0;
    tick();
    chk++; if (tx_trigger !== ~exp_trig || tx_data !== 8'h50)
      $display("FAIL tmo_b0: got trig %b data %h want %b 50",
               tx_trigger, tx_data, ~exp_trig); else pass++;
    exp_trig = ~exp_trig;
    for (int i = 0; i < 15; i++) tick();
    chk++; if (timeout_err !== 1'b0 || busy !== 1'b1)
      $display("FAIL tmo_early: got err %b busy %b want 0 1",
               timeout_err, busy); else pass++;
    tick();
    chk++; if (timeout_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL tmo_fire: got err %b busy %b want 1 0",
               timeout_err, busy); else pass++;
    wait_issue(8'h51, "tmo_next");
    chk++; if (timeout_err !== 1'b1)
      $display("FAIL tmo_sticky: got %b want 1", timeout_err); else pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk++; if (timeout_err !== 1'b0)
      $display("FAIL tmo_clr: got %b want 0", timeout_err); else pass++;
    finish_pulse();
  endtask

  task automatic test_same_cycle();
    req1_valid = 1'b1;
    req1_data = 8'h70;
    tick();
    req1_data = 8'h71;
    tick();
    chk++; if (fifo_count !== 3'd2 || busy !== 1'b1)
      $display("FAIL same_pre: got cnt %0d busy %b want 2 1",
               fifo_count, busy); else pass++;
    req1_data = 8'h72;
    tick();
    req1_valid = 1'b0;
    chk++; if (fifo_count !== 3'd2)
      $display("FAIL same_cnt: got %0d want 2", fifo_count); else pass++;
    wait_issue(8'h70, "same_b0");
    finish_pulse();
    wait_issue(8'h71, "same_b1");
    finish_pulse();
    wait_issue(8'h72, "same_b2");
    finish_pulse();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1;
      req0_data = 8'h80 + 8'(i);
      tick();
    end
    req0_valid = 1'b0;
    wait_issue(8'h80, "mid_b0");
    chk++; if (fifo_count !== 3'd3 || busy !== 1'b1)
      $display("FAIL mid_pre: got cnt %0d busy %b want 3 1",
               fifo_count, busy); else pass++;
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    chk++; if (fifo_count !== 3'd0 || busy !== 1'b0)
      $display("FAIL mid_rst: got cnt %0d busy %b want 0 0",
               fifo_count, busy); else pass++;
    chk++; if (tx_data !== 8'h00 || tx_trigger !== 1'b0)
      $display("FAIL mid_tx: got data %h trig %b want 00 0",
               tx_data, tx_trigger); else pass++;
    chk++; if (tx_enable !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL mid_en: got en %b err %b want 0 0",
               tx_enable, timeout_err); else pass++;
    chk++; if ({req1_ready, req0_ready} !== 2'b00)
      $display("FAIL mid_ready: got %b want 00",
               {req1_ready, req0_ready}); else pass++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    exp_trig = 1'b0;
    tick();
    finish_pulse();
    tick();
    tick();
    chk++; if (busy !== 1'b0 || tx_trigger !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL mid_late: got busy %b trig %b cnt %0d want 0 0 0",
               busy, tx_trigger, fifo_count); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
